// File: rtl/alu_flags.sv
// alu_flags: N-bit add/subtract ALU with a registered carry/zero flag pair.
//
// Sits between the A/B registers and the shared data bus of the 8-bit bus CPU.
// The datapath is purely combinational; only the flag register is clocked.
//
// Ports:
//   clk     in      system clock; flags update on rising edge
//   rst     in      asynchronous active-high reset of the flag register
//   a, b    in  N   operands
//   su      in      0 = a + b, 1 = a - b
//   eo_     in      active-low result output enable onto bus
//   fi_     in      active-low flags-in strobe (load cf/zf at posedge clk)
//   bus     out N   tri-state result; high-impedance when eo_ = 1
//   cf, zf  out     registered carry / zero flags
//   cf_int  out     combinational carry-out of the current operation
//   zf_int  out     combinational zero of the current result
module alu_flags #(
   parameter int unsigned N = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         su,
   input  logic         eo_,
   input  logic         fi_,
   output wire  [N-1:0] bus,
   output logic         cf,
   output logic         zf,
   output logic         cf_int,
   output logic         zf_int
);

   logic [N-1:0] b_eff;
   logic [N:0]   sum;
   logic [N-1:0] result;

   logic cf_d, cf_q;
   logic zf_d, zf_q;

   // Subtract as a + ~b + 1, so the carry-out reads as "no borrow".
   always_comb begin
      b_eff  = su ? ~b : b;
      sum    = {1'b0, a} + {1'b0, b_eff} + {{N{1'b0}}, su};
      result = sum[N-1:0];
      cf_int = sum[N];
      zf_int = (result == '0);
   end

   // Release the bus completely when not enabled so other drivers win cleanly.
   assign bus = eo_ ? {N{1'bz}} : result;

   always_comb begin
      cf_d = cf_q;
      zf_d = zf_q;
      if (!fi_) begin
         cf_d = cf_int;
         zf_d = zf_int;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cf_q <= 1'b0;
         zf_q <= 1'b0;
      end else begin
         cf_q <= cf_d;
         zf_q <= zf_d;
      end
   end

   assign cf = cf_q;
   assign zf = zf_q;

endmodule

// File: tb/tb_alu_flags.sv
// Self-checking bench for alu_flags: directed cases followed by a random sweep
// compared against an arithmetic reference model of the add/subtract rules.
module tb_alu_flags;

   localparam int unsigned N = 8;
   localparam int Mod = 1 << N;

   logic         clk;
   logic         rst;
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic         su;
   logic         eo_;
   logic         fi_;
   wire  [N-1:0] bus;
   logic         cf;
   logic         zf;
   logic         cf_int;
   logic         zf_int;

   // Second bus driver, only ever enabled while the DUT has eo_ = 1.
   logic         drv_en;
   logic [N-1:0] drv_val;
   assign bus = drv_en ? drv_val : {N{1'bz}};

   int n_checks;
   int n_fail;

   alu_flags #(
      .N(N)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .a      (a),
      .b      (b),
      .su     (su),
      .eo_    (eo_),
      .fi_    (fi_),
      .bus    (bus),
      .cf     (cf),
      .zf     (zf),
      .cf_int (cf_int),
      .zf_int (zf_int)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Reference: plain integer arithmetic on the documented add/subtract rules.
   function automatic void ref_model(input int av, input int bv, input bit s,
                                     output int res, output bit c, output bit z);
      int full;
      if (!s) begin
         full = av + bv;
         res  = full % Mod;
         c    = (full >= Mod);
      end else begin
         res = (av - bv + Mod) % Mod;
         c   = (av >= bv);
      end
      z = (res == 0);
   endfunction

   task automatic apply(input int av, input int bv, input bit s);
      @(negedge clk);
      a  = N'(av);
      b  = N'(bv);
      su = s;
      #1;
   endtask

   task automatic check_comb(input string tag, input int av, input int bv, input bit s);
      int res;
      bit c;
      bit z;
      ref_model(av, bv, s, res, c, z);
      check({tag, "_bus"}, int'(bus), res);
      check({tag, "_cf_int"}, int'(cf_int), int'(c));
      check({tag, "_zf_int"}, int'(zf_int), int'(z));
   endtask

   initial begin
      int res;
      bit c;
      bit z;
      bit exp_cf;
      bit exp_zf;
      int av;
      int bv;
      bit s;
      bit fi;
      bit eo;

      n_checks = 0;
      n_fail   = 0;
      rst      = 1'b1;
      a        = '0;
      b        = '0;
      su       = 1'b0;
      eo_      = 1'b0;
      fi_      = 1'b1;
      drv_en   = 1'b0;
      drv_val  = '0;

      #12;
      check("reset_cf", int'(cf), 0);
      check("reset_zf", int'(zf), 0);
      @(negedge clk);
      rst = 1'b0;

      // Zero operands, then load flags.
      apply(0, 0, 1'b0);
      check_comb("zero", 0, 0, 1'b0);
      fi_ = 1'b0;
      @(posedge clk);
      #1;
      check("zero_load_cf", int'(cf), 0);
      check("zero_load_zf", int'(zf), 1);
      fi_ = 1'b1;

      apply(34, 12, 1'b0);
      check_comb("add34_12", 34, 12, 1'b0);
      check("add34_12_lit", int'(bus), 46);
      apply(34, 12, 1'b1);
      check_comb("sub34_12", 34, 12, 1'b1);
      check("sub34_12_lit", int'(bus), 22);
      apply(12, 34, 1'b1);
      check_comb("sub12_34", 12, 34, 1'b1);
      check("sub12_34_lit", int'(bus), 234);
      apply(200, 100, 1'b0);
      check_comb("add200_100", 200, 100, 1'b0);
      check("add200_100_lit", int'(bus), 44);
      apply(128, 128, 1'b0);
      check_comb("add128_128", 128, 128, 1'b0);
      apply(255, 1, 1'b0);
      check_comb("add255_1", 255, 1, 1'b0);
      apply(0, 1, 1'b1);
      check_comb("sub0_1", 0, 1, 1'b1);

      // Load cf=1, zf=1 from a=b=77 subtract.
      apply(77, 77, 1'b1);
      check_comb("sub77_77", 77, 77, 1'b1);
      fi_ = 1'b0;
      @(posedge clk);
      #1;
      check("load77_cf", int'(cf), 1);
      check("load77_zf", int'(zf), 1);

      // Hold across three edges with different operands.
      apply(1, 1, 1'b0);
      fi_ = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         check("hold_cf", int'(cf), 1);
         check("hold_zf", int'(zf), 1);
      end

      // Asynchronous reset between edges.
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("async_rst_cf", int'(cf), 0);
      check("async_rst_zf", int'(zf), 0);
      @(negedge clk);
      fi_ = 1'b0;
      @(posedge clk);
      #1;
      check("rst_held_cf", int'(cf), 0);
      check("rst_held_zf", int'(zf), 0);
      @(negedge clk);
      rst = 1'b0;
      fi_ = 1'b1;

      // Bus release: second driver must win uncontested while eo_ = 1.
      apply(34, 12, 1'b0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         eo_     = i[0];
         drv_val = N'(8'hA5 + i);
         drv_en  = i[0];
         #1;
         if (i[0]) check("bus_release", int'(bus), 8'hA5 + i);
         else      check("bus_drive", int'(bus), 46);
         check("eo_cf_int", int'(cf_int), 0);
      end
      @(negedge clk);
      drv_en = 1'b0;
      eo_    = 1'b0;

      // Random sweep against the reference model, tracking the flag register.
      exp_cf = 1'b0;
      exp_zf = 1'b0;
      for (int i = 0; i < 1200; i++) begin
         av = int'($urandom_range(Mod - 1, 0));
         bv = int'($urandom_range(Mod - 1, 0));
         if (i % 16 == 0) bv = av;
         s  = 1'($urandom);
         fi = 1'($urandom);
         eo = ($urandom_range(3, 0) == 0);
         @(negedge clk);
         a       = N'(av);
         b       = N'(bv);
         su      = s;
         fi_     = fi;
         eo_     = eo;
         drv_val = N'($urandom);
         drv_en  = eo;
         #1;
         ref_model(av, bv, s, res, c, z);
         check("rnd_bus", int'(bus), eo ? int'(drv_val) : res);
         check("rnd_cf_int", int'(cf_int), int'(c));
         check("rnd_zf_int", int'(zf_int), int'(z));
         if (!fi) begin
            exp_cf = c;
            exp_zf = z;
         end
         @(posedge clk);
         #1;
         check("rnd_cf", int'(cf), int'(exp_cf));
         check("rnd_zf", int'(zf), int'(exp_zf));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
